bicintp_pingpong_buf: RTL and testbench

- Downstream stage of the bicubic interpolation calculator.
- Collects interpolated RGB565 pixels (cmos_bicintp_data / cmos_bicintp_data_vld) into two line banks used ping-pong.
- Hands each completed line to the DDR write side through a word-by-word read interface.
- Decouples the bursty one-in-four pixel rate of the calculator from DDR burst timing.

---
 rtl/bicintp_pingpong_buf_pkg.sv | 21 ++
 rtl/bicintp_pingpong_buf_pp_bank_ram.sv | 42 ++++
 rtl/bicintp_pingpong_buf.sv | 123 ++++++++++++
 tb/tb_bicintp_pingpong_buf.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bicintp_pingpong_buf_pkg.sv
// Shared pixel-format definitions for the bicubic interpolation datapath.
// The calculator and the ping-pong line buffer both import this package.
package bicintp_pingpong_buf_pkg;

  localparam int PIX_W = 16;
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int B_OFF = 0;
  localparam int G_OFF = B_OFF + B_W;
  localparam int R_OFF = G_OFF + G_W;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/bicintp_pingpong_buf_pp_bank_ram.sv
// Simple dual-port line RAM holding both ping-pong banks, addressed {bank, addr}.
// One write port and one synchronous read port whose output holds between reads.
module pp_bank_ram
  import bicintp_pingpong_buf_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [ADDR_W:0] wr_addr,
  input  pix_t            wr_data,
  input  logic            rd_en,
  input  logic [ADDR_W:0] rd_addr,
  output pix_t            rd_data
);

  // Bank 1 starts at 2**ADDR_W, so the array spans the full {bank, addr} space.
  pix_t mem [2**(ADDR_W+1)];
  pix_t rd_data_d;
  pix_t rd_data_q;

  // NOTE: the storage array has no reset; resetting it would prevent block-RAM
  // inference, and its contents are don't-care after reset anyway.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Output register clears on reset so the read port shows zero until first read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bicintp_pingpong_buf.sv
// Ping-pong line buffer between the bicubic calculator and the DDR write side.
// Fills one bank while the other is drained word-by-word; drops pixels when both are full.
module bicintp_pingpong_buf
  import bicintp_pingpong_buf_pkg::*;
#(
  parameter int LINE_PIX = 640,
  parameter int ADDR_W   = 10
) (
  input  logic sys_clk,
  input  logic sys_rstn,
  input  logic frame_start,
  input  pix_t cmos_bicintp_data,
  input  logic cmos_bicintp_data_vld,
  output logic buf_rdy,
  output logic rd_bank,
  input  logic ddr_rd_en,
  output pix_t ddr_rd_data,
  output logic ddr_rd_data_vld,
  output logic ovf_flag
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_PIX - 1);

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              ovf_q, ovf_d;
  logic              rd_vld_q, rd_vld_d;
  logic              wr_accept;
  logic              rd_accept;
  logic              wr_drop;

  // frame_start masks both ports so a clearing cycle never touches the RAM or ovf.
  assign wr_accept = cmos_bicintp_data_vld && !bank_full_q[wr_bank_q] && !frame_start;
  assign wr_drop   = cmos_bicintp_data_vld &&  bank_full_q[wr_bank_q] && !frame_start;
  assign rd_accept = ddr_rd_en && bank_full_q[rd_bank_q] && !frame_start;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    bank_full_d = bank_full_q;
    ovf_d       = ovf_q;
    rd_vld_d    = rd_accept;

    if (frame_start) begin
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      wr_addr_d   = '0;
      rd_addr_d   = '0;
      bank_full_d = 2'b00;
      ovf_d       = 1'b0;
    end else begin
      if (wr_accept) begin
        if (wr_addr_q == LAST_ADDR) begin
          bank_full_d[wr_bank_q] = 1'b1;
          wr_addr_d              = '0;
          wr_bank_d              = ~wr_bank_q;
        end else begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
      end
      if (wr_drop) ovf_d = 1'b1;

      // A completing read always targets the other bank than a completing write.
      if (rd_accept) begin
        if (rd_addr_q == LAST_ADDR) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_addr_d              = '0;
          rd_bank_d              = ~rd_bank_q;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update
  // together from the values computed above.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      bank_full_q <= 2'b00;
      ovf_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      bank_full_q <= bank_full_d;
      ovf_q       <= ovf_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  pp_bank_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (sys_clk),
    .rst_n   (sys_rstn),
    .wr_en   (wr_accept),
    .wr_addr ({wr_bank_q, wr_addr_q}),
    .wr_data (cmos_bicintp_data),
    .rd_en   (rd_accept),
    .rd_addr ({rd_bank_q, rd_addr_q}),
    .rd_data (ddr_rd_data)
  );

  assign buf_rdy         = bank_full_q[rd_bank_q];
  assign rd_bank         = rd_bank_q;
  assign ddr_rd_data_vld = rd_vld_q;
  assign ovf_flag        = ovf_q;

endmodule

// File: tb/tb_bicintp_pingpong_buf.sv
// Scoreboard bench for the ping-pong line buffer with LINE_PIX=8.
// Stimulus queues expected read words; a negedge monitor pops and compares them.
module tb_bicintp_pingpong_buf;
  import bicintp_pingpong_buf_pkg::*;

  localparam int LINE_PIX = 8;
  localparam int ADDR_W   = 3;

  logic sys_clk = 1'b0;
  logic sys_rstn;
  logic frame_start;
  pix_t cmos_bicintp_data;
  logic cmos_bicintp_data_vld;
  logic buf_rdy;
  logic rd_bank;
  logic ddr_rd_en;
  pix_t ddr_rd_data;
  logic ddr_rd_data_vld;
  logic ovf_flag;

  int   checks = 0;
  int   errors = 0;
  pix_t exp_q[$];

  always #5 sys_clk = ~sys_clk;

  bicintp_pingpong_buf #(
    .LINE_PIX (LINE_PIX),
    .ADDR_W   (ADDR_W)
  ) dut (
    .sys_clk               (sys_clk),
    .sys_rstn              (sys_rstn),
    .frame_start           (frame_start),
    .cmos_bicintp_data     (cmos_bicintp_data),
    .cmos_bicintp_data_vld (cmos_bicintp_data_vld),
    .buf_rdy               (buf_rdy),
    .rd_bank               (rd_bank),
    .ddr_rd_en             (ddr_rd_en),
    .ddr_rd_data           (ddr_rd_data),
    .ddr_rd_data_vld       (ddr_rd_data_vld),
    .ovf_flag              (ovf_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid read word must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    if (sys_rstn === 1'b1 && ddr_rd_data_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h, want none (t=%0t)", ddr_rd_data, $time);
      end else begin
        check("rd_data", 32'(ddr_rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One pixel strobe followed by three idle cycles (calculator one-in-four rate).
  task automatic write_pix(input pix_t d);
    cmos_bicintp_data     = d;
    cmos_bicintp_data_vld = 1'b1;
    tick();
    cmos_bicintp_data_vld = 1'b0;
  endtask

  task automatic write_line(input pix_t base, input int n);
    for (int i = 0; i < n; i++) begin
      write_pix(pix_t'(base + pix_t'(i)));
      if (i != n - 1) idle(3);
    end
  endtask

  task automatic expect_seq(input pix_t base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pix_t'(base + pix_t'(i)));
  endtask

  // Back-to-back reads; each accepted request must yield vld on the next cycle.
  task automatic read_burst(input int n);
    for (int i = 0; i < n; i++) begin
      ddr_rd_en = 1'b1;
      tick();
      check("rd_vld_contig", 32'(ddr_rd_data_vld), 32'd1);
    end
    ddr_rd_en = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rstn              = 1'b1;
    frame_start           = 1'b0;
    cmos_bicintp_data     = '0;
    cmos_bicintp_data_vld = 1'b0;
    ddr_rd_en             = 1'b0;
    #2 sys_rstn = 1'b0;
    #1;
    check("rst_buf_rdy", 32'(buf_rdy), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'd0);
    check("rst_rd_data", 32'(ddr_rd_data), 32'd0);
    check("rst_rd_vld",  32'(ddr_rd_data_vld), 32'd0);
    check("rst_ovf",     32'(ovf_flag), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rstn = 1'b1;
    tick();

    // 1: single line, one pixel every 4 cycles, then 8 reads.
    write_line(16'h0001, 7);
    idle(3);
    check("t1_not_rdy_7", 32'(buf_rdy), 32'd0);
    write_pix(16'h0008);
    check("t1_buf_rdy", 32'(buf_rdy), 32'd1);
    check("t1_rd_bank", 32'(rd_bank), 32'd0);
    expect_seq(16'h0001, 8);
    read_burst(8);
    check("t1_rdy_low", 32'(buf_rdy), 32'd0);
    drain();

    // 2: two lines, 16 back-to-back reads crossing banks seamlessly.
    pulse_frame_start();
    write_line(16'h0100, 16);
    check("t2_buf_rdy", 32'(buf_rdy), 32'd1);
    expect_seq(16'h0100, 16);
    read_burst(8);
    check("t2_rd_bank_mid", 32'(rd_bank), 32'd1);
    check("t2_rdy_mid", 32'(buf_rdy), 32'd1);
    read_burst(8);
    check("t2_rd_bank_end", 32'(rd_bank), 32'd0);
    check("t2_rdy_end", 32'(buf_rdy), 32'd0);
    drain();

    // 3: 17 pixels, the 17th overflows and is dropped.
    write_line(16'h0200, 16);
    idle(3);
    check("t3_no_ovf_16", 32'(ovf_flag), 32'd0);
    write_pix(16'h0210);
    check("t3_ovf", 32'(ovf_flag), 32'd1);
    expect_seq(16'h0200, 16);
    read_burst(16);
    check("t3_rdy_end", 32'(buf_rdy), 32'd0);
    drain();

    // 4: reads while not ready are ignored; next line still starts at word 0.
    ddr_rd_en = 1'b1;
    tick();
    check("t4_no_vld_a", 32'(ddr_rd_data_vld), 32'd0);
    tick();
    ddr_rd_en = 1'b0;
    check("t4_no_vld_b", 32'(ddr_rd_data_vld), 32'd0);
    check("t4_rd_bank", 32'(rd_bank), 32'd0);
    write_line(16'h0300, 8);
    check("t4_ovf_sticky", 32'(ovf_flag), 32'd1);
    expect_seq(16'h0300, 8);
    read_burst(8);
    drain();

    // 5: frame_start with a coincident pixel discards the partial line.
    write_line(16'h0400, 5);
    idle(3);
    cmos_bicintp_data     = 16'h04FF;
    cmos_bicintp_data_vld = 1'b1;
    pulse_frame_start();
    cmos_bicintp_data_vld = 1'b0;
    check("t5_fs_rdy", 32'(buf_rdy), 32'd0);
    check("t5_fs_ovf", 32'(ovf_flag), 32'd0);
    write_line(16'hA000, 7);
    idle(3);
    check("t5_not_rdy_7", 32'(buf_rdy), 32'd0);
    write_pix(16'hA007);
    check("t5_buf_rdy", 32'(buf_rdy), 32'd1);
    check("t5_rd_bank", 32'(rd_bank), 32'd0);
    expect_seq(16'hA000, 8);
    read_burst(8);
    check("t5_ovf_end", 32'(ovf_flag), 32'd0);
    drain();

    // 6: async reset in the middle of reading a full line (bank 1).
    write_line(16'h0500, 8);
    check("t6_buf_rdy", 32'(buf_rdy), 32'd1);
    check("t6_rd_bank", 32'(rd_bank), 32'd1);
    expect_seq(16'h0500, 3);
    read_burst(3);
    @(negedge sys_clk);
    #1;
    ddr_rd_en = 1'b1;
    sys_rstn  = 1'b0;
    #1;
    check("t6_rst_rdy",  32'(buf_rdy), 32'd0);
    check("t6_rst_bank", 32'(rd_bank), 32'd0);
    check("t6_rst_data", 32'(ddr_rd_data), 32'd0);
    check("t6_rst_vld",  32'(ddr_rd_data_vld), 32'd0);
    check("t6_rst_ovf",  32'(ovf_flag), 32'd0);
    ddr_rd_en = 1'b0;
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rstn = 1'b1;
    tick();
    write_line(16'h0600, 8);
    check("t6_new_rdy", 32'(buf_rdy), 32'd1);
    check("t6_new_bank", 32'(rd_bank), 32'd0);
    expect_seq(16'h0600, 8);
    read_burst(8);
    drain();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
